// File: rtl/cog_loader_pkg.sv
// rtl/cog_loader_pkg.sv - shared FSM state type and default load size for the cog loader
package cog_loader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WRITE = 2'd2,
        FIN   = 2'd3
    } state_e;

    localparam int DEFAULT_LOAD_LONGS = 496;

endpackage

// File: rtl/cog_loader_if.sv
// rtl/cog_loader_if.sv - hub read handshake plus cog RAM write port bundle
interface cog_loader_if #(
    parameter int BIT_DEPTH = 9,
    parameter int HUB_AW    = 14
);
    logic                 hub_req;
    logic [HUB_AW-1:0]    hub_addr;
    logic                 hub_ack;
    logic [31:0]          hub_data;
    logic                 ram_ena;
    logic                 ram_w;
    logic [BIT_DEPTH-1:0] ram_a;
    logic [31:0]          ram_d;

    modport master (
        output hub_req, hub_addr, ram_ena, ram_w, ram_a, ram_d,
        input  hub_ack, hub_data
    );

    modport slave (
        input  hub_req, hub_addr, ram_ena, ram_w, ram_a, ram_d,
        output hub_ack, hub_data
    );
endinterface

// File: rtl/cog_loader.sv
// rtl/cog_loader.sv - copies LOAD_LONGS consecutive hub longs into cog RAM 0..LOAD_LONGS-1
module cog_loader
    import cog_loader_pkg::*;
#(
    parameter int BIT_DEPTH  = 9,
    parameter int LOAD_LONGS = DEFAULT_LOAD_LONGS,
    parameter int HUB_AW     = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [HUB_AW-1:0] ptr,
    output logic              busy,
    output logic              done,
    cog_loader_if.master      bus
);

    localparam logic [BIT_DEPTH:0] LAST_COUNT = (BIT_DEPTH+1)'(LOAD_LONGS - 1);

    state_e               state_q, state_d;
    logic [BIT_DEPTH:0]   count_q, count_d;
    logic [HUB_AW-1:0]    base_q, base_d;
    logic [HUB_AW-1:0]    hub_addr_q, hub_addr_d;
    logic                 hub_req_q, hub_req_d;
    logic                 ram_we_q, ram_we_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [BIT_DEPTH-1:0] ram_a_q, ram_a_d;
    logic [31:0]          ram_d_q, ram_d_d;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        base_d  = base_q;
        ram_a_d = ram_a_q;
        ram_d_d = ram_d_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    base_d  = ptr;
                    count_d = '0;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (bus.hub_ack) begin
                    ram_d_d = bus.hub_data;
                    ram_a_d = count_q[BIT_DEPTH-1:0];
                    state_d = WRITE;
                end
            end
            WRITE: begin
                if (count_q == LAST_COUNT) begin
                    state_d = FIN;
                end else begin
                    count_d = count_q + (BIT_DEPTH+1)'(1);
                    state_d = REQ;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs are decoded from the next state so they appear registered
        // in the same cycle the FSM enters that state.
        hub_req_d  = (state_d == REQ);
        ram_we_d   = (state_d == WRITE);
        busy_d     = (state_d == REQ) || (state_d == WRITE);
        done_d     = (state_d == FIN);
        hub_addr_d = hub_req_d ? (base_d + HUB_AW'(count_d)) : hub_addr_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            count_q    <= '0;
            base_q     <= '0;
            hub_addr_q <= '0;
            hub_req_q  <= 1'b0;
            ram_we_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ram_a_q    <= '0;
            ram_d_q    <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            base_q     <= base_d;
            hub_addr_q <= hub_addr_d;
            hub_req_q  <= hub_req_d;
            ram_we_q   <= ram_we_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            ram_a_q    <= ram_a_d;
            ram_d_q    <= ram_d_d;
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign bus.hub_req  = hub_req_q;
    assign bus.hub_addr = hub_addr_q;
    assign bus.ram_ena  = ram_we_q;
    assign bus.ram_w    = ram_we_q;
    assign bus.ram_a    = ram_a_q;
    assign bus.ram_d    = ram_d_q;

endmodule

// File: tb/tb_cog_loader.sv
// tb/tb_cog_loader.sv - directed self-checking bench for cog_loader with hub and RAM models
module tb_cog_loader;
    import cog_loader_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        rst;
    logic        start, start_dl;
    logic [13:0] ptr;
    logic        busy4, done4, busy_dl, done_dl;
    logic        spur_ack;
    logic        clr4, clrd;

    cog_loader_if #(.BIT_DEPTH(9), .HUB_AW(14)) bus4 ();
    cog_loader_if #(.BIT_DEPTH(9), .HUB_AW(14)) busd ();

    cog_loader #(.BIT_DEPTH(9), .LOAD_LONGS(4), .HUB_AW(14)) dut4 (
        .clk(clk), .rst(rst), .start(start), .ptr(ptr),
        .busy(busy4), .done(done4), .bus(bus4.master)
    );

    cog_loader #(.BIT_DEPTH(9), .LOAD_LONGS(496), .HUB_AW(14)) dutd (
        .clk(clk), .rst(rst), .start(start_dl), .ptr(ptr),
        .busy(busy_dl), .done(done_dl), .bus(busd.master)
    );

    // Hub model: ack after ack_delay4 cycles of a pending request; data = addr ^ A5A5_0000
    int ack_delay4 = 0;
    int wait4 = 0;
    always @(posedge clk) wait4 <= (bus4.hub_req && !bus4.hub_ack) ? wait4 + 1 : 0;
    assign bus4.hub_ack  = (bus4.hub_req && (wait4 >= ack_delay4)) || spur_ack;
    assign bus4.hub_data = {18'h0, bus4.hub_addr} ^ 32'hA5A5_0000;
    assign busd.hub_ack  = busd.hub_req;
    assign busd.hub_data = {18'h0, busd.hub_addr} ^ 32'hA5A5_0000;

    logic [31:0] mem4 [512];
    logic [31:0] memd [512];
    always @(posedge clk) begin
        if (clr4) begin
            for (int i = 0; i < 512; i++) mem4[i] <= 32'hDEAD_0000 | 32'(i);
        end else if (bus4.ram_ena && bus4.ram_w) begin
            mem4[bus4.ram_a] <= bus4.ram_d;
        end
    end
    always @(posedge clk) begin
        if (clrd) begin
            for (int i = 0; i < 512; i++) memd[i] <= 32'hDEAD_0000 | 32'(i);
        end else if (busd.ram_ena && busd.ram_w) begin
            memd[busd.ram_a] <= busd.ram_d;
        end
    end

    int errors = 0;
    int checks = 0;

    int          n_done, t_done, unstable, busy_bad, late_req;
    logic [13:0] req_q [$];
    logic [8:0]  wr_a_q [$];

    task automatic clear_mem4();
        @(negedge clk); clr4 = 1'b1;
        @(negedge clk); clr4 = 1'b0;
    endtask

    task automatic run_load4(input logic [13:0] p, input int delay, input bit restart, input int window);
        int          t0;
        logic        prev_req;
        logic [13:0] prev_addr;
        ack_delay4 = delay;
        n_done = 0; t_done = -1; unstable = 0; busy_bad = 0; late_req = 0;
        req_q.delete(); wr_a_q.delete();
        prev_req = 1'b0; prev_addr = '0;
        @(negedge clk);
        ptr = p; start = 1'b1; t0 = cyc;
        for (int i = 1; i <= window; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (done4) begin n_done++; t_done = cyc - t0; end
            if (n_done > 0 && !done4 && bus4.hub_req) late_req++;
            if (bus4.ram_ena && bus4.ram_w) wr_a_q.push_back(bus4.ram_a);
            if (bus4.hub_req) begin
                if (prev_req && bus4.hub_addr !== prev_addr) unstable++;
                if (bus4.hub_ack) req_q.push_back(bus4.hub_addr);
            end
            if (busy4 !== (bus4.hub_req | bus4.ram_w)) busy_bad++;
            prev_req  = bus4.hub_req && !bus4.hub_ack;
            prev_addr = bus4.hub_addr;
            if (restart && (bus4.hub_req || done4)) begin start = 1'b1; ptr = 14'h2000; end
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        int bad;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy4, done4, bus4.hub_req, bus4.ram_ena, bus4.ram_w} !== 5'b0) begin
            errors++; $display("FAIL reset_strobes got=%b exp=00000", {busy4, done4, bus4.hub_req, bus4.ram_ena, bus4.ram_w});
        end
        checks++;
        if ({bus4.hub_addr, bus4.ram_a, bus4.ram_d} !== 55'b0) begin
            errors++; $display("FAIL reset_buses got addr=%h a=%h d=%h exp=0", bus4.hub_addr, bus4.ram_a, bus4.ram_d);
        end
        checks++;
        if ({busy_dl, done_dl, busd.hub_req, busd.ram_w} !== 4'b0) begin
            errors++; $display("FAIL reset_default_strobes got=%b exp=0000", {busy_dl, done_dl, busd.hub_req, busd.ram_w});
        end
        rst = 1'b0;
        bad = 0;
        spur_ack = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (bus4.hub_req || bus4.ram_w || busy4) bad++;
        end
        spur_ack = 1'b0;
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL idle_spurious_ack got=%0d active cycles exp=0", bad); end
    endtask

    task automatic test_basic();
        clear_mem4();
        run_load4(14'h0100, 0, 1'b0, 14);
        checks++;
        if (n_done !== 1) begin errors++; $display("FAIL basic_done_count got=%0d exp=1", n_done); end
        checks++;
        if (t_done !== 9) begin errors++; $display("FAIL basic_done_cycle got=%0d exp=9", t_done); end
        checks++;
        if (wr_a_q.size() !== 4) begin errors++; $display("FAIL basic_write_count got=%0d exp=4", wr_a_q.size()); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (mem4[i] !== 32'hA5A5_0100 + 32'(i)) begin
                errors++; $display("FAIL basic_ram[%0d] got=%h exp=%h", i, mem4[i], 32'hA5A5_0100 + 32'(i));
            end
        end
        checks++;
        if (mem4[4] !== 32'hDEAD_0004) begin errors++; $display("FAIL basic_ram4_untouched got=%h exp=dead0004", mem4[4]); end
        checks++;
        if (busy4 !== 1'b0 || busy_bad !== 0) begin
            errors++; $display("FAIL basic_busy got busy=%b bad=%0d exp busy=0 bad=0", busy4, busy_bad);
        end
    endtask

    task automatic test_ack_delay();
        clear_mem4();
        run_load4(14'h0040, 3, 1'b0, 30);
        checks++;
        if (unstable !== 0) begin errors++; $display("FAIL delay_addr_stable got=%0d changes exp=0", unstable); end
        checks++;
        if (wr_a_q.size() !== 4) begin errors++; $display("FAIL delay_write_count got=%0d exp=4", wr_a_q.size()); end
        checks++;
        if (t_done !== 21) begin errors++; $display("FAIL delay_done_cycle got=%0d exp=21", t_done); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (mem4[i] !== 32'hA5A5_0040 + 32'(i)) begin
                errors++; $display("FAIL delay_ram[%0d] got=%h exp=%h", i, mem4[i], 32'hA5A5_0040 + 32'(i));
            end
        end
    endtask

    task automatic test_wrap();
        logic [13:0] exp_addr [4];
        exp_addr[0] = 14'h3FFE; exp_addr[1] = 14'h3FFF; exp_addr[2] = 14'h0000; exp_addr[3] = 14'h0001;
        clear_mem4();
        run_load4(14'h3FFE, 0, 1'b0, 14);
        checks++;
        if (req_q.size() !== 4 || wr_a_q.size() !== 4) begin
            errors++; $display("FAIL wrap_counts got req=%0d wr=%0d exp=4/4", req_q.size(), wr_a_q.size());
        end
        for (int i = 0; i < 4 && i < req_q.size() && i < wr_a_q.size(); i++) begin
            checks++;
            if (req_q[i] !== exp_addr[i] || wr_a_q[i] !== 9'(i)) begin
                errors++; $display("FAIL wrap_seq[%0d] got addr=%h a=%0d exp addr=%h a=%0d", i, req_q[i], wr_a_q[i], exp_addr[i], i);
            end
        end
        checks++;
        if (mem4[2] !== 32'hA5A5_0000) begin errors++; $display("FAIL wrap_ram2 got=%h exp=a5a50000", mem4[2]); end
    endtask

    task automatic test_restart();
        clear_mem4();
        run_load4(14'h0200, 0, 1'b1, 20);
        checks++;
        if (n_done !== 1 || late_req !== 0) begin
            errors++; $display("FAIL restart_single_load got done=%0d late_req=%0d exp=1/0", n_done, late_req);
        end
        checks++;
        if (t_done !== 9) begin errors++; $display("FAIL restart_done_cycle got=%0d exp=9", t_done); end
        checks++;
        if (req_q.size() !== 4) begin errors++; $display("FAIL restart_req_count got=%0d exp=4", req_q.size()); end
        for (int i = 0; i < req_q.size() && i < 4; i++) begin
            checks++;
            if (req_q[i] !== 14'h0200 + 14'(i)) begin
                errors++; $display("FAIL restart_base[%0d] got=%h exp=%h", i, req_q[i], 14'h0200 + 14'(i));
            end
        end
    endtask

    task automatic test_rst_mid();
        int writes;
        int bad;
        clear_mem4();
        ack_delay4 = 0;
        @(negedge clk);
        ptr = 14'h0300; start = 1'b1;
        writes = 0;
        for (int i = 0; i < 20 && writes < 2; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (bus4.ram_w) writes++;
        end
        checks++;
        if (writes !== 2) begin errors++; $display("FAIL rstmid_two_writes got=%0d exp=2", writes); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (dut4.state_q !== IDLE || {busy4, done4, bus4.hub_req, bus4.ram_ena, bus4.ram_w} !== 5'b0) begin
            errors++; $display("FAIL rstmid_idle got state=%0d strobes=%b exp state=0 strobes=00000",
                               dut4.state_q, {busy4, done4, bus4.hub_req, bus4.ram_ena, bus4.ram_w});
        end
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (done4 || bus4.ram_w || bus4.hub_req) bad++;
        end
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL rstmid_quiet got=%0d active cycles exp=0", bad); end
        checks++;
        if (mem4[0] !== 32'hA5A5_0300 || mem4[1] !== 32'hA5A5_0301 || mem4[2] !== 32'hDEAD_0002) begin
            errors++; $display("FAIL rstmid_partial got %h %h %h exp a5a50300 a5a50301 dead0002", mem4[0], mem4[1], mem4[2]);
        end
        run_load4(14'h0310, 0, 1'b0, 14);
        checks++;
        if (n_done !== 1 || wr_a_q.size() !== 4) begin
            errors++; $display("FAIL rstmid_reload got done=%0d writes=%0d exp=1/4", n_done, wr_a_q.size());
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (mem4[i] !== 32'hA5A5_0310 + 32'(i)) begin
                errors++; $display("FAIL rstmid_ram[%0d] got=%h exp=%h", i, mem4[i], 32'hA5A5_0310 + 32'(i));
            end
        end
    endtask

    task automatic test_default();
        int t0, nw, aerr, nd, td, bad_data, bad_tail;
        @(negedge clk);
        ptr = 14'h1000; start_dl = 1'b1; t0 = cyc;
        nw = 0; aerr = 0; nd = 0; td = -1;
        for (int i = 1; i <= 1100; i++) begin
            @(negedge clk);
            start_dl = 1'b0;
            if (busd.ram_ena && busd.ram_w) begin
                if (busd.ram_a !== 9'(nw)) aerr++;
                nw++;
            end
            if (done_dl) begin nd++; td = cyc - t0; end
        end
        checks++;
        if (nw !== 496 || aerr !== 0) begin errors++; $display("FAIL default_writes got=%0d addr_errs=%0d exp=496/0", nw, aerr); end
        checks++;
        if (nd !== 1 || td !== 993) begin errors++; $display("FAIL default_done got count=%0d cycle=%0d exp=1/993", nd, td); end
        bad_data = 0; bad_tail = 0;
        for (int i = 0; i < 496; i++) if (memd[i] !== 32'hA5A5_1000 + 32'(i)) bad_data++;
        for (int i = 496; i < 512; i++) if (memd[i] !== (32'hDEAD_0000 | 32'(i))) bad_tail++;
        checks++;
        if (bad_data !== 0) begin errors++; $display("FAIL default_data got=%0d bad words exp=0", bad_data); end
        checks++;
        if (bad_tail !== 0) begin errors++; $display("FAIL default_tail got=%0d touched words exp=0", bad_tail); end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; start_dl = 1'b0; ptr = '0;
        spur_ack = 1'b0; clr4 = 1'b1; clrd = 1'b1;
        repeat (2) @(negedge clk);
        clr4 = 1'b0; clrd = 1'b0;
        test_reset();
        test_basic();
        test_ack_delay();
        test_wrap();
        test_restart();
        test_rst_mid();
        test_default();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
